// File: rtl/cls_sub_clk.sv
// Multi-cycle two's-complement subtractor: D = A + ~B + 1, one CHUNK-bit slice per cycle.
// Optional macro CLS_ZERO_FLAG_EN adds an o_zero result flag.
module cls_sub_clk #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_d,
    output logic             o_bout,
`ifdef CLS_ZERO_FLAG_EN
    output logic             o_zero,
`endif
    output logic             o_v
);

    localparam int NCHK = WIDTH / CHUNK;
    localparam int IDXW = (NCHK > 1) ? $clog2(NCHK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] ra, rnb, shadow, shadow_next;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] a_sl, b_sl, s;
    logic             c, msb_cin, last;
    int               base;

    assign last   = (idx == LAST_IDX);
    assign o_busy = (state != IDLE);

    // One slice of the ripple; carry into the slice MSB is recovered from the sum bit.
    always_comb begin
        base        = int'(idx) * CHUNK;
        a_sl        = ra[base +: CHUNK];
        b_sl        = rnb[base +: CHUNK];
        {c, s}      = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
        msb_cin     = s[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
        shadow_next = shadow;
        shadow_next[base +: CHUNK] = s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (last)    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra     <= '0;
            rnb    <= '0;
            shadow <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            o_done <= 1'b0;
            o_d    <= '0;
            o_bout <= 1'b0;
            o_v    <= 1'b0;
`ifdef CLS_ZERO_FLAG_EN
            o_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        ra     <= i_a;
                        rnb    <= ~i_b;
                        carry  <= 1'b1;
                        idx    <= '0;
                        shadow <= '0;
                    end
                end
                RUN: begin
                    shadow <= shadow_next;
                    carry  <= c;
                    idx    <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        o_d    <= shadow_next;
                        o_bout <= ~c;
                        o_v    <= msb_cin ^ c;
                        o_done <= 1'b1;
`ifdef CLS_ZERO_FLAG_EN
                        o_zero <= (shadow_next == '0);
`endif
                    end
                end
                DONE: o_done <= 1'b0;
                default: o_done <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_cls_sub_clk.sv
// Self-checking bench for cls_sub_clk: vector table plus hand sequences, results scored via a queue.
module tb_cls_sub_clk;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             i_start = 1'b0;
    logic [WIDTH-1:0] i_a = '0;
    logic [WIDTH-1:0] i_b = '0;
    logic             o_busy, o_done, o_bout, o_v;
    logic [WIDTH-1:0] o_d;
`ifdef CLS_ZERO_FLAG_EN
    logic             o_zero;
`endif

    cls_sub_clk #(.WIDTH(WIDTH), .CHUNK(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_d     (o_d),
        .o_bout  (o_bout),
`ifdef CLS_ZERO_FLAG_EN
        .o_zero  (o_zero),
`endif
        .o_v     (o_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             v;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             v;
        logic             zero;
    } exp_t;

    exp_t             sb_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] last_d = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Result scoreboard: every completion pops one expected record.
    always @(negedge clk) begin
        if (!reset && o_done) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: o_d=0x%0h with no request pending at %0t", o_d, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_d", o_d, e.d);
                check("result_bout", o_bout, e.bout);
                check("result_v", o_v, e.v);
`ifdef CLS_ZERO_FLAG_EN
                check("result_zero", o_zero, e.zero);
`endif
                last_d = e.d;
            end
        end
    end

    // Called on a negedge with the DUT idle; returns on the negedge after DONE (IDLE again).
    // glitch > 0 re-asserts start with zero operands after edge 'glitch'; it must be ignored.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] ed, input logic eb, input logic ev,
                          input int glitch);
        exp_t e;
        int   done_k;
        e.d = ed; e.bout = eb; e.v = ev; e.zero = (ed == '0);
        i_start = 1'b1; i_a = a; i_b = b;
        sb_q.push_back(e);
        @(negedge clk);
        i_start = 1'b0;
        done_k = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == glitch) begin
                i_start = 1'b1; i_a = '0; i_b = '0;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) begin
                done_k = k;
                break;
            end
            check("busy_run", o_busy, 1);
            check("hold_d", o_d, last_d);
        end
        check("done_latency", done_k, 4);
        check("busy_done", o_busy, 1);
        @(negedge clk);
        i_start = 1'b0;
        check("done_one_cycle", o_done, 0);
        check("busy_idle", o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{32'd5,          32'd3,          32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'd3,          32'd5,          32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0100,  32'd1,          32'h0000_00FF, 1'b0, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 1'b0, 1'b0};
        vecs[6] = '{32'h1234_5678,  32'h9ABC_DEF0,  32'h7777_7788, 1'b1, 1'b0};

        #1 reset = 1'b1;
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_d", o_d, 0);
        check("rst_bout", o_bout, 0);
        check("rst_v", o_v, 0);
`ifdef CLS_ZERO_FLAG_EN
        check("rst_zero", o_zero, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Table vectors, issued back-to-back at the minimum interval.
        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bout, vecs[i].v, 0);

        // Second start during RUN (sampled at edge 2) must be ignored.
        run_op(32'd10, 32'd4, 32'd6, 1'b0, 1'b0, 1);
        repeat (8) @(negedge clk);

        // Reset between edges 2 and 3 of an operation: no completion, outputs cleared at once.
        i_start = 1'b1; i_a = 32'd9; i_b = 32'd1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", o_busy, 0);
        check("midrst_done", o_done, 0);
        check("midrst_d", o_d, 0);
        check("midrst_bout", o_bout, 0);
        check("midrst_v", o_v, 0);
        @(negedge clk);
        reset = 1'b0;
        last_d = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_done_after_rst", o_done, 0);
        end

        // Zero result, then back-to-back with the previous result held until completion.
        run_op(32'd7, 32'd7, 32'h0000_0000, 1'b0, 1'b0, 0);
        run_op(32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
        repeat (4) @(negedge clk);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
